seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for a bank of common-anode 7-segment digits.

---
 rtl/seg_scan_driver.sv | 149 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for common-anode 7-segment digits with double-buffered
// input, leading-zero suppression and anti-ghost anode blanking at each slot start.
module seg_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pendData_q, pendData_d, actData_q, actData_d;
  logic [DIGITS-1:0]     pendDp_q, pendDp_d, actDp_q, actDp_d;
  logic [DIGITS-1:0]     pendBlank_q, pendBlank_d, actBlank_q, actBlank_d;
  logic                  pendFlag_q, pendFlag_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frameDone_q, frameDone_d;

  logic                  lastCnt, frameWrap, seen, curDp, curBlank, curSup;
  logic [3:0]            curCode;
  logic [DIGITS-1:0]     suppress;

  // Segment patterns g..a, active low.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h18;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    lastCnt   = (cnt_q == CW'(SCAN_DIV - 1));
    frameWrap = lastCnt && (idx_q == IW'(DIGITS - 1));
    cnt_d     = lastCnt ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (lastCnt) idx_d = frameWrap ? '0 : idx_q + 1'b1;

    pendData_d  = pendData_q;
    pendDp_d    = pendDp_q;
    pendBlank_d = pendBlank_q;
    pendFlag_d  = pendFlag_q;
    actData_d   = actData_q;
    actDp_d     = actDp_q;
    actBlank_d  = actBlank_q;
    // Commit uses the registered pending copy, so a load in the wrap cycle waits a frame.
    if (frameWrap && pendFlag_q) begin
      actData_d  = pendData_q;
      actDp_d    = pendDp_q;
      actBlank_d = pendBlank_q;
      pendFlag_d = 1'b0;
    end
    if (load) begin
      pendData_d  = data;
      pendDp_d    = dp_in;
      pendBlank_d = blank;
      pendFlag_d  = 1'b1;
    end
  end

  always_comb begin
    seen     = 1'b0;
    suppress = '0;
    curCode  = 4'h0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    curSup   = 1'b0;
    an_d     = '1;
    // Walk from the most significant digit down until a nonzero code or a dp appears.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen        = seen | (actData_q[4*i +: 4] != 4'h0) | actDp_q[i];
      suppress[i] = lz_en && (i != 0) && !seen;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        curCode  = actData_q[4*i +: 4];
        curDp    = actDp_q[i];
        curBlank = actBlank_q[i];
        curSup   = suppress[i];
      end
      an_d[i] = !((cnt_q >= CW'(BLANK_CYC)) && (idx_q == IW'(i)));
    end
    seg_d = {~curDp, decode(curCode)};
    if (curBlank || curSup) seg_d = 8'hFF;
    frameDone_d = frameWrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pendData_q  <= '0;
      pendDp_q    <= '0;
      pendBlank_q <= '0;
      pendFlag_q  <= 1'b0;
      actData_q   <= '0;
      actDp_q     <= '0;
      actBlank_q  <= '0;
      an_q        <= '1;
      seg_q       <= 8'hFF;
      frameDone_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pendData_q  <= pendData_d;
      pendDp_q    <= pendDp_d;
      pendBlank_q <= pendBlank_d;
      pendFlag_q  <= pendFlag_d;
      actData_q   <= actData_d;
      actDp_q     <= actDp_d;
      actBlank_q  <= actBlank_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: stimulus pushes expected frames into a scoreboard,
// a monitor captures each full frame after frame_done and checks it.
module tb_seg_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  typedef struct {
    int          frame;
    logic [31:0] segs;
  } expT;

  expT        sbQ[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  int         frameCnt = 0;
  int         pos = 0;
  bit         monOn = 1'b0;
  bit         inFrame = 1'b0;
  logic [7:0] segS[FRAME];
  logic [3:0] anS[FRAME];

  seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .blank(blank),
    .lz_en(lz_en), .load(load), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp,
                               input logic [3:0] bl, input logic lz);
    data  = d;
    dp_in = dp;
    blank = bl;
    lz_en = lz;
    load  = 1'b1;
    @(negedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic waitFrame(output int k);
    k = -1;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      #1;
      if (frame_done) begin
        k = frameCnt;
        break;
      end
    end
    if (k < 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL waitFrame timeout: got no frame_done, expected one within %0d cycles", 3 * FRAME);
      k = frameCnt;
    end
  endtask

  task automatic pushExp(input int f, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
    expT e;
    e.frame = f;
    e.segs  = {s3, s2, s1, s0};
    sbQ.push_back(e);
  endtask

  task automatic checkFrame(input int f);
    logic [31:0] exp;
    logic [3:0]  expAn;
    bit          have;
    int          d, c;
    expT         e;
    have = 1'b0;
    exp  = '0;
    while (sbQ.size() > 0 && sbQ[0].frame < f) begin
      e = sbQ.pop_front();
      checkOutput($sformatf("frame %0d not checked", e.frame), f, e.frame);
    end
    if (sbQ.size() > 0 && sbQ[0].frame == f) begin
      e    = sbQ.pop_front();
      exp  = e.segs;
      have = 1'b1;
    end
    for (int p = 0; p < FRAME; p++) begin
      d     = p / SCAN_DIV;
      c     = p % SCAN_DIV;
      expAn = (c < BLANK_CYC) ? 4'hF : ~(4'b0001 << d);
      checkOutput($sformatf("an f%0d slot%0d", f, p), anS[p], expAn);
      if (have) checkOutput($sformatf("seg f%0d dig%0d slot%0d", f, d, p), segS[p], exp[8*d +: 8]);
    end
  endtask

  // Monitor: the FRAME samples following a frame_done belong to that frame.
  initial begin
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (inFrame) begin
          segS[pos] = seg;
          anS[pos]  = an;
          pos++;
          if (pos == FRAME) begin
            checkFrame(frameCnt);
            checkOutput($sformatf("frameDone period f%0d", frameCnt), frame_done, 1);
            pos = 0;
          end else if (frame_done) begin
            checkOutput($sformatf("frameDone early f%0d slot%0d", frameCnt, pos), frame_done, 0);
          end
        end
        if (frame_done) begin
          frameCnt++;
          inFrame = 1'b1;
          pos     = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    // Reset asserted mid-scan forces idle outputs at once.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("an before reset", an, 4'b1101);
    rst_n = 1'b0;
    #1;
    checkOutput("an in reset", an, 4'hF);
    checkOutput("seg in reset", seg, 8'hFF);
    checkOutput("frameDone in reset", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    monOn = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("an 1 cycle after release", an, 4'hF);
    checkOutput("seg 1 cycle after release", seg, 8'hC0);
    @(negedge clk);
    #1;
    checkOutput("an 2 cycles after release", an, 4'b1110);

    waitFrame(k);
    applyStimulus(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    pushExp(k + 1, 8'h8E, 8'h88, 8'hA4, 8'hF9);

    waitFrame(k);
    applyStimulus(16'h0005, 4'b0000, 4'b0000, 1'b1);
    pushExp(k + 1, 8'h92, 8'hFF, 8'hFF, 8'hFF);

    waitFrame(k);
    applyStimulus(16'h0005, 4'b0100, 4'b0000, 1'b1);
    pushExp(k + 1, 8'h92, 8'hC0, 8'h40, 8'hFF);

    // Two mid-frame loads: only the last one reaches the next frame.
    waitFrame(k);
    repeat (5) @(negedge clk);
    #1;
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b1);
    pushExp(k + 1, 8'hA4, 8'hA4, 8'hA4, 8'hA4);

    // Load in the wrap cycle of frame k shows up in frame k+2.
    waitFrame(k);
    repeat (FRAME - 1) @(negedge clk);
    #1;
    applyStimulus(16'h3333, 4'b0000, 4'b1000, 1'b1);
    pushExp(k + 1, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
    pushExp(k + 2, 8'hB0, 8'hB0, 8'hB0, 8'hFF);

    waitFrame(k);
    applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
    pushExp(k + 1, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    waitFrame(k);
    waitFrame(k);
    #1;
    checkOutput("scoreboard drained", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
